// File: rtl/hazard_frame_loader.sv
// hazard_frame_loader: receives a framed byte stream of hazard boxes, checks
// each box against the grid, packs the accepted ones into a shadow set and
// commits the whole frame atomically to the flattened output buses.
module hazard_frame_loader #(
  parameter logic [7:0] MAX_ROW     = 8'd7,
  parameter logic [7:0] MAX_COL     = 8'd31,
  parameter logic [3:0] SYNC_NIBBLE = 4'hA
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [7:0]   in_data,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         frame_abort,
  output logic [3:0]   num_hazards,
  output logic [127:0] top_flat,
  output logic [127:0] left_flat,
  output logic [127:0] bottom_flat,
  output logic [127:0] right_flat,
  output logic         frame_valid,
  output logic         frame_err,
  output logic [3:0]   dropped
);

  localparam int unsigned BUS_W = 128;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RECV   = 2'd1,
    S_COMMIT = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [3:0]         remain_q, remain_d;
  logic [1:0]         slot_q, slot_d;
  logic [3:0]         wr_q, wr_d;
  logic [3:0]         drop_q, drop_d;
  logic [23:0]        stage_q, stage_d;
  logic [BUS_W-1:0]   sh_top_q, sh_top_d;
  logic [BUS_W-1:0]   sh_left_q, sh_left_d;
  logic [BUS_W-1:0]   sh_bot_q, sh_bot_d;
  logic [BUS_W-1:0]   sh_right_q, sh_right_d;
  logic [BUS_W-1:0]   out_top_q, out_top_d;
  logic [BUS_W-1:0]   out_left_q, out_left_d;
  logic [BUS_W-1:0]   out_bot_q, out_bot_d;
  logic [BUS_W-1:0]   out_right_q, out_right_d;
  logic [3:0]         num_q, num_d;
  logic [3:0]         dropped_q, dropped_d;
  logic               fv_q, fv_d;
  logic               fe_q, fe_d;

  logic               in_fire;
  logic               hdr_ok;
  logic [7:0]         r_top, r_left, r_bot, r_right;
  logic               rec_ok;
  logic [6:0]         wr_bit;

  // Ready is held low while reset is asserted and for the single commit cycle.
  assign in_ready = !rst && (state_q != S_COMMIT);
  assign in_fire  = in_valid && in_ready;
  assign hdr_ok   = (in_data[7:4] == SYNC_NIBBLE);

  // The fourth byte of a record completes it on the wire; no extra stage.
  assign r_top   = stage_q[7:0];
  assign r_left  = stage_q[15:8];
  assign r_bot   = stage_q[23:16];
  assign r_right = in_data;
  assign rec_ok  = (r_top <= r_bot) && (r_left <= r_right) &&
                   (r_bot <= MAX_ROW) && (r_right <= MAX_COL);
  assign wr_bit  = {wr_q, 3'b000};

  // Next-state and datapath updates for the frame receiver.
  always_comb begin
    state_d     = state_q;
    remain_d    = remain_q;
    slot_d      = slot_q;
    wr_d        = wr_q;
    drop_d      = drop_q;
    stage_d     = stage_q;
    sh_top_d    = sh_top_q;
    sh_left_d   = sh_left_q;
    sh_bot_d    = sh_bot_q;
    sh_right_d  = sh_right_q;
    out_top_d   = out_top_q;
    out_left_d  = out_left_q;
    out_bot_d   = out_bot_q;
    out_right_d = out_right_q;
    num_d       = num_q;
    dropped_d   = dropped_q;
    fv_d        = 1'b0;
    fe_d        = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (in_fire && !frame_abort && hdr_ok) begin
          remain_d   = in_data[3:0];
          slot_d     = 2'd0;
          wr_d       = 4'd0;
          drop_d     = 4'd0;
          sh_top_d   = '0;
          sh_left_d  = '0;
          sh_bot_d   = '0;
          sh_right_d = '0;
          state_d    = (in_data[3:0] != 4'd0) ? S_RECV : S_COMMIT;
        end
      end

      S_RECV: begin
        if (frame_abort) begin
          state_d    = S_IDLE;
          slot_d     = 2'd0;
          wr_d       = 4'd0;
          drop_d     = 4'd0;
          sh_top_d   = '0;
          sh_left_d  = '0;
          sh_bot_d   = '0;
          sh_right_d = '0;
        end else if (in_fire) begin
          slot_d = slot_q + 2'd1;
          case (slot_q)
            2'd0: stage_d[7:0]   = in_data;
            2'd1: stage_d[15:8]  = in_data;
            2'd2: stage_d[23:16] = in_data;
            default: begin
              if (rec_ok) begin
                sh_top_d[wr_bit +: 8]   = r_top;
                sh_left_d[wr_bit +: 8]  = r_left;
                sh_bot_d[wr_bit +: 8]   = r_bot;
                sh_right_d[wr_bit +: 8] = r_right;
                wr_d = wr_q + 4'd1;
              end else begin
                drop_d = drop_q + 4'd1;
              end
              remain_d = remain_q - 4'd1;
              if (remain_q == 4'd1) begin
                state_d = S_COMMIT;
              end
            end
          endcase
        end
      end

      S_COMMIT: begin
        out_top_d   = sh_top_q;
        out_left_d  = sh_left_q;
        out_bot_d   = sh_bot_q;
        out_right_d = sh_right_q;
        num_d       = wr_q;
        dropped_d   = drop_q;
        fv_d        = 1'b1;
        fe_d        = (drop_q != 4'd0);
        state_d     = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  // State, shadow and committed-output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      remain_q    <= 4'd0;
      slot_q      <= 2'd0;
      wr_q        <= 4'd0;
      drop_q      <= 4'd0;
      stage_q     <= 24'd0;
      sh_top_q    <= '0;
      sh_left_q   <= '0;
      sh_bot_q    <= '0;
      sh_right_q  <= '0;
      out_top_q   <= '0;
      out_left_q  <= '0;
      out_bot_q   <= '0;
      out_right_q <= '0;
      num_q       <= 4'd0;
      dropped_q   <= 4'd0;
      fv_q        <= 1'b0;
      fe_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      remain_q    <= remain_d;
      slot_q      <= slot_d;
      wr_q        <= wr_d;
      drop_q      <= drop_d;
      stage_q     <= stage_d;
      sh_top_q    <= sh_top_d;
      sh_left_q   <= sh_left_d;
      sh_bot_q    <= sh_bot_d;
      sh_right_q  <= sh_right_d;
      out_top_q   <= out_top_d;
      out_left_q  <= out_left_d;
      out_bot_q   <= out_bot_d;
      out_right_q <= out_right_d;
      num_q       <= num_d;
      dropped_q   <= dropped_d;
      fv_q        <= fv_d;
      fe_q        <= fe_d;
    end
  end

  assign num_hazards = num_q;
  assign top_flat    = out_top_q;
  assign left_flat   = out_left_q;
  assign bottom_flat = out_bot_q;
  assign right_flat  = out_right_q;
  assign dropped     = dropped_q;
  assign frame_valid = fv_q;
  assign frame_err   = fe_q;

endmodule

// File: tb/tb_hazard_frame_loader.sv
// Scoreboard bench for hazard_frame_loader: frames are sent with hand-computed
// expectations queued; a negedge monitor checks every committed frame.
module tb_hazard_frame_loader;

  logic         clk;
  logic         rst;
  logic [7:0]   in_data;
  logic         in_valid;
  logic         in_ready;
  logic         frame_abort;
  logic [3:0]   num_hazards;
  logic [127:0] top_flat, left_flat, bottom_flat, right_flat;
  logic         frame_valid;
  logic         frame_err;
  logic [3:0]   dropped;

  hazard_frame_loader dut (
    .clk         (clk),
    .rst         (rst),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .frame_abort (frame_abort),
    .num_hazards (num_hazards),
    .top_flat    (top_flat),
    .left_flat   (left_flat),
    .bottom_flat (bottom_flat),
    .right_flat  (right_flat),
    .frame_valid (frame_valid),
    .frame_err   (frame_err),
    .dropped     (dropped)
  );

  typedef struct {
    logic [3:0]   num;
    logic [127:0] t, l, b, r;
    logic [3:0]   drp;
    logic         err;
  } exp_t;

  exp_t       exp_q[$];
  exp_t       cur;
  logic [7:0] frm[$];
  int         total = 0;
  int         bad   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic push_exp(input logic [3:0] num, input logic [127:0] t, input logic [127:0] l,
                          input logic [127:0] b, input logic [127:0] r,
                          input logic [3:0] drp, input logic err);
    exp_t e;
    e.num = num; e.t = t; e.l = l; e.b = b; e.r = r; e.drp = drp; e.err = err;
    exp_q.push_back(e);
  endtask

  // Drive one byte after an optional idle gap; it transfers at the next posedge.
  task automatic send_byte(input logic [7:0] b, input int gap);
    int guard;
    repeat (gap) begin
      @(negedge clk);
      in_valid = 1'b0;
    end
    @(negedge clk);
    in_data  = b;
    in_valid = 1'b1;
    chk("ready_while_sending", 128'(in_ready), 128'(1'b1));
    guard = 0;
    while (!in_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (!in_ready) begin
      total++; bad++;
      $display("FAIL ready_timeout actual=0 required=1");
    end
    @(posedge clk);
  endtask

  // Send frm[] and check the commit-cycle ready drop and the pulse timing.
  task automatic send_frame(input bit toggle, input int long_gap_at);
    int gap;
    for (int i = 0; i < frm.size(); i++) begin
      gap = toggle ? 1 : 0;
      if (i == long_gap_at) gap = 10;
      send_byte(frm[i], gap);
    end
    @(negedge clk);
    in_valid = 1'b0;
    chk("commit_ready_low", 128'(in_ready), 128'(1'b0));
    chk("pulse_not_early", 128'(frame_valid), 128'(1'b0));
    @(negedge clk);
    chk("pulse_on_time", 128'(frame_valid), 128'(1'b1));
    chk("ready_after_commit", 128'(in_ready), 128'(1'b1));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("ready_in_reset", 128'(in_ready), 128'(1'b0));
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_num", 128'(num_hazards), 128'(0));
    chk("rst_buses", top_flat | left_flat | bottom_flat | right_flat, 128'(0));
    chk("rst_dropped", 128'(dropped), 128'(0));
    chk("rst_pulses", 128'({frame_valid, frame_err}), 128'(0));
    chk("rst_ready", 128'(in_ready), 128'(1'b1));
  endtask

  // Monitor: every commit pulse pops one expectation.
  always @(negedge clk) begin
    if (!rst && frame_err && !frame_valid) begin
      total++; bad++;
      $display("FAIL err_without_valid actual=1 required=0");
    end
    if (!rst && frame_valid) begin
      if (exp_q.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_pulse actual=1 required=0");
      end else begin
        cur = exp_q.pop_front();
        chk("num_hazards", 128'(num_hazards), 128'(cur.num));
        chk("top_flat", top_flat, cur.t);
        chk("left_flat", left_flat, cur.l);
        chk("bottom_flat", bottom_flat, cur.b);
        chk("right_flat", right_flat, cur.r);
        chk("dropped", 128'(dropped), 128'(cur.drp));
        chk("frame_err", 128'(frame_err), 128'(cur.err));
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int guard;
    rst = 1'b1; in_data = 8'h00; in_valid = 1'b0; frame_abort = 1'b0;
    do_reset();

    // Two valid boxes
    push_exp(4'd2, 128'h0600, 128'h1400, 128'h0701, 128'h1902, 4'd0, 1'b0);
    frm = '{8'hA2, 8'h00, 8'h00, 8'h01, 8'h02, 8'h06, 8'h14, 8'h07, 8'h19};
    send_frame(1'b0, -1);

    // Two of three dropped (top>bottom, bottom>MAX_ROW)
    push_exp(4'd1, 128'h01, 128'h01, 128'h01, 128'h01, 4'd2, 1'b1);
    frm = '{8'hA3, 8'h05, 8'h00, 8'h02, 8'h03, 8'h01, 8'h01, 8'h01, 8'h01,
            8'h00, 8'h00, 8'h08, 8'h00};
    send_frame(1'b0, -1);

    // Bad sync ignored, then an empty frame
    send_byte(8'h35, 0);
    push_exp(4'd0, 128'h0, 128'h0, 128'h0, 128'h0, 4'd0, 1'b0);
    frm = '{8'hA0};
    send_frame(1'b0, -1);

    // 0xFF coordinates fail the grid checks
    push_exp(4'd0, 128'h0, 128'h0, 128'h0, 128'h0, 4'd1, 1'b1);
    frm = '{8'hA1, 8'h00, 8'h00, 8'hFF, 8'hFF};
    send_frame(1'b0, -1);

    // Commit, then abort a partial frame; outputs must hold
    push_exp(4'd1, 128'h02, 128'h03, 128'h04, 128'h05, 4'd0, 1'b0);
    frm = '{8'hA1, 8'h02, 8'h03, 8'h04, 8'h05};
    send_frame(1'b0, -1);
    frm = '{8'hA2, 8'h10, 8'h11, 8'h12, 8'h13, 8'h14};
    for (int i = 0; i < frm.size(); i++) send_byte(frm[i], 0);
    @(negedge clk);
    in_valid = 1'b0;
    frame_abort = 1'b1;
    @(negedge clk);
    frame_abort = 1'b0;
    repeat (3) @(negedge clk);
    chk("abort_hold_num", 128'(num_hazards), 128'(1));
    chk("abort_hold_top", top_flat, 128'h02);
    chk("abort_hold_right", right_flat, 128'h05);
    push_exp(4'd1, 128'h02, 128'h03, 128'h04, 128'h05, 4'd0, 1'b0);
    frm = '{8'hA1, 8'h02, 8'h03, 8'h04, 8'h05};
    send_frame(1'b0, -1);

    // Scenario 1 again with bubbles and one long gap
    push_exp(4'd2, 128'h0600, 128'h1400, 128'h0701, 128'h1902, 4'd0, 1'b0);
    frm = '{8'hA2, 8'h00, 8'h00, 8'h01, 8'h02, 8'h06, 8'h14, 8'h07, 8'h19};
    send_frame(1'b1, 5);

    // Reset in the middle of a record after a committed frame
    frm = '{8'hA1, 8'h01, 8'h01};
    for (int i = 0; i < frm.size(); i++) send_byte(frm[i], 0);
    do_reset();
    // Boundary boxes exactly at MAX_ROW/MAX_COL
    push_exp(4'd2, 128'h0703, 128'h1F04, 128'h0705, 128'h1F06, 4'd0, 1'b0);
    frm = '{8'hA2, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h1F, 8'h07, 8'h1F};
    send_frame(1'b0, -1);

    guard = 0;
    while (exp_q.size() != 0 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    chk("all_frames_seen", 128'(exp_q.size()), 128'(0));
    repeat (5) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
